// File: rtl/aib_tx_flit_pkg.sv
// Shared types and constants for the AIB Tx flit arbiter: flit header layout and arbiter state.
package aib_tx_flit_pkg;

    localparam int unsigned FLIT_W     = 72;
    localparam int unsigned PAYLOAD_W  = 64;
    localparam int unsigned HDR_W      = 8;
    localparam int unsigned SRC_ID_W   = 2;
    localparam int unsigned HDR_SEQ_W  = 4;

    // Occupies flit bits [71:64], MSB first.
    typedef struct packed {
        logic [SRC_ID_W-1:0]  src_id;
        logic [HDR_SEQ_W-1:0] seq;
        logic                 last;
        logic                 parity;
    } flit_hdr_t;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/aib_tx_skid_buf.sv
// Two-entry flit buffer between the arbiter and the channel Tx stream.
// space_o is registered so upstream ready never depends combinationally on rd_ready_i.
module aib_tx_skid_buf
    import aib_tx_flit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [FLIT_W-1:0] wr_data_i,
    output logic              space_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [FLIT_W-1:0] rd_data_o
);

    logic [1:0][FLIT_W-1:0] mem_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic                   space_q;
    logic                   rd_en;

    assign rd_en = (count_q != 2'd0) && rd_ready_i;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, rd_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // space_q resets low so no source is offered ready while reset is asserted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            space_q  <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            space_q <= (count_d != 2'd2);
        end
    end

    assign space_o    = space_q;
    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/aib_tx_flit_arbiter.sv
// Round-robin, packet-locked merge of up to four 64-bit sources into the 72-bit channel Tx stream.
// Define AIB_TX_ARB_PARITY_EN to generate even parity in flit bit 64; otherwise it is tied to 0.
module aib_tx_flit_arbiter
    import aib_tx_flit_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEQ_W   = 4
) (
    input  logic                              i_bus_clk,
    input  logic                              i_rst,
    input  logic [NUM_SRC-1:0]                i_src_valid,
    output logic [NUM_SRC-1:0]                o_src_ready,
    input  logic [NUM_SRC-1:0][PAYLOAD_W-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]                i_src_last,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic [FLIT_W-1:0]                 o_tx_data,
    output logic                              o_locked,
    output logic [SRC_ID_W-1:0]               o_grant_src
);

    localparam int NSRC = int'(NUM_SRC);

    arb_state_e                    state_q, state_d;
    logic [SRC_ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SRC_ID_W-1:0]           grant_q, grant_d;
    logic [NUM_SRC-1:0][SEQ_W-1:0] seq_q, seq_d;
    logic [SRC_ID_W-1:0]           winner;
    logic [SRC_ID_W-1:0]           sel;
    logic [SRC_ID_W-1:0]           idx;
    int                            sum;
    logic                          space;
    logic                          hs;
    logic                          sel_last;
    flit_hdr_t                     hdr;
    logic [PAYLOAD_W-1:0]          payload;
    logic [FLIT_W-1:0]             flit;

    function automatic logic [SRC_ID_W-1:0] next_src(input logic [SRC_ID_W-1:0] s);
        return (int'(s) == NSRC - 1) ? '0 : s + SRC_ID_W'(1);
    endfunction

    // Scan downward so the last hit is the first valid index at or after rr_ptr.
    always_comb begin
        winner = rr_ptr_q;
        sum    = 0;
        idx    = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NSRC) begin
                sum = sum - NSRC;
            end
            idx = SRC_ID_W'(sum);
            if (i_src_valid[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        seq_d       = seq_q;
        sel         = (state_q == LOCKED) ? grant_q : winner;
        o_src_ready = '0;
        o_src_ready[sel] = space;
        hs          = i_src_valid[sel] & space;
        sel_last    = i_src_last[sel];
        if (hs) begin
            if (sel_last) begin
                state_d    = IDLE;
                rr_ptr_d   = next_src(sel);
                seq_d[sel] = seq_q[sel] + SEQ_W'(1);
            end else begin
                state_d = LOCKED;
                grant_d = sel;
            end
        end
    end

    always_comb begin
        hdr.src_id = sel;
        hdr.seq    = seq_q[sel];
        hdr.last   = sel_last;
        hdr.parity = 1'b0;
        payload    = i_src_data[sel];
`ifdef AIB_TX_ARB_PARITY_EN
        hdr.parity = ^{hdr.src_id, hdr.seq, hdr.last, payload};
`endif
        flit = {hdr, payload};
    end

    always_ff @(posedge i_bus_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            seq_q    <= seq_d;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_grant_src = grant_q;

    aib_tx_skid_buf u_skid_buf (
        .clk_i      (i_bus_clk),
        .rst_i      (i_rst),
        .wr_en_i    (hs),
        .wr_data_i  (flit),
        .space_o    (space),
        .rd_valid_o (o_tx_valid),
        .rd_ready_i (i_tx_ready),
        .rd_data_o  (o_tx_data)
    );

endmodule

// File: tb/tb_aib_tx_flit_arbiter.sv
// Directed bench for aib_tx_flit_arbiter; emitted flits are captured and compared against
// hand-built expected flits.
module tb_aib_tx_flit_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       src_valid;
    logic [3:0]       src_ready;
    logic [3:0][63:0] src_data;
    logic [3:0]       src_last;
    logic             tx_valid;
    logic             tx_ready;
    logic [71:0]      tx_data;
    logic             locked;
    logic [1:0]       grant;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [71:0]      got[$];
    logic [71:0]      exp_q[$];

    aib_tx_flit_arbiter #(.NUM_SRC(4), .SEQ_W(4)) dut (
        .i_bus_clk   (clk),
        .i_rst       (rst),
        .i_src_valid (src_valid),
        .o_src_ready (src_ready),
        .i_src_data  (src_data),
        .i_src_last  (src_last),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_locked    (locked),
        .o_grant_src (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [71:0] mk(input logic [1:0] s, input logic [3:0] q, input logic l,
                                       input logic [63:0] p);
        logic [71:0] f;
        f = {s, q, l, 1'b0, p};
`ifdef AIB_TX_ARB_PARITY_EN
        f[64] = ^{f[71:65], f[63:0]};
`endif
        return f;
    endfunction

    task automatic wait_ready(input logic [3:0] mask, output int waited);
        waited = 0;
        #1;
        while (((src_valid & src_ready & mask) == 4'd0) && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("ready_timeout", 72'(waited >= 50), 72'(0));
    endtask

    task automatic send(input logic [1:0] s, input logic [63:0] d, input logic l, output int waited);
        src_valid[s] = 1'b1;
        src_data[s]  = d;
        src_last[s]  = l;
        wait_ready(4'(1 << s), waited);
        @(posedge clk);
        #1;
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_flits(input string tag);
        check({tag, "_count"}, 72'(got.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 72'hx, exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        src_last  = '0;
        tx_ready  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s;
        int cnt[4];
        logic [63:0] p;

        rst       = 1'b1;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        tx_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx_valid", 72'(tx_valid), 72'(0));
        check("rst_tx_data", tx_data, 72'(0));
        check("rst_src_ready", 72'(src_ready), 72'(0));
        check("rst_locked", 72'(locked), 72'(0));
        check("rst_grant", 72'(grant), 72'(0));
        rst = 1'b0;

        // 1: three-beat packet from source 0
        send(2'd0, 64'h1, 1'b0, w);
        check("t1_valid_latency", 72'(tx_valid), 72'(1));
        check("t1_data_latency", tx_data, mk(2'd0, 4'd0, 1'b0, 64'h1));
        check("t1_locked_b1", 72'(locked), 72'(1));
        check("t1_grant_b1", 72'(grant), 72'(0));
        send(2'd0, 64'h2, 1'b0, w);
        check("t1_wait_b2", 72'(w), 72'(0));
        check("t1_locked_b2", 72'(locked), 72'(1));
        send(2'd0, 64'h3, 1'b1, w);
        check("t1_wait_b3", 72'(w), 72'(0));
        check("t1_locked_b3", 72'(locked), 72'(0));
        drain();
        exp_q.push_back(mk(2'd0, 4'd0, 1'b0, 64'h1));
        exp_q.push_back(mk(2'd0, 4'd0, 1'b0, 64'h2));
        exp_q.push_back(mk(2'd0, 4'd0, 1'b1, 64'h3));
        expect_flits("t1_flit");

        // 2: all four sources, two single-beat packets each
        do_reset();
        cnt = '{default: 0};
        for (int i = 0; i < 4; i++) src_data[i] = 64'hA0 + 64'(i);
        src_valid = 4'hF;
        src_last  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_ready(4'hF, w);
            s = 0;
            for (int i = 0; i < 4; i++) if (src_valid[i] && src_ready[i]) s = i;
            @(posedge clk);
            #1;
            cnt[s]++;
            if (cnt[s] == 2) src_valid[s] = 1'b0;
        end
        src_valid = '0;
        src_last  = '0;
        drain();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(2'(i), 4'(r), 1'b1, 64'hA0 + 64'(i)));
        end
        expect_flits("t2_flit");

        // 3: source 1 bubbles mid-packet while source 2 waits
        src_valid[2] = 1'b1;
        src_data[2]  = 64'hC2;
        src_last[2]  = 1'b1;
        send(2'd1, 64'hB1, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_bubble", 72'(src_ready), 72'(4'b0010));
            check("t3_locked_bubble", 72'(locked), 72'(1));
            check("t3_grant_bubble", 72'(grant), 72'(1));
            @(posedge clk);
            #1;
        end
        check("t3_no_src2_flit", 72'(got.size()), 72'(1));
        send(2'd1, 64'hB2, 1'b1, w);
        send(2'd2, 64'hC2, 1'b1, w);
        drain();
        exp_q.push_back(mk(2'd1, 4'd2, 1'b0, 64'hB1));
        exp_q.push_back(mk(2'd1, 4'd2, 1'b1, 64'hB2));
        exp_q.push_back(mk(2'd2, 4'd2, 1'b1, 64'hC2));
        expect_flits("t3_flit");

        // 4: channel backpressure for five cycles
        tx_ready = 1'b0;
        send(2'd0, 64'hD0, 1'b1, w);
        send(2'd0, 64'hD1, 1'b1, w);
        src_valid[0] = 1'b1;
        src_data[0]  = 64'hD2;
        src_last[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_ready_full", 72'(src_ready), 72'(0));
            check("t4_valid_held", 72'(tx_valid), 72'(1));
            check("t4_data_held", tx_data, mk(2'd0, 4'd2, 1'b1, 64'hD0));
            @(posedge clk);
            #1;
        end
        check("t4_none_emitted", 72'(got.size()), 72'(0));
        tx_ready = 1'b1;
        send(2'd0, 64'hD2, 1'b1, w);
        send(2'd0, 64'hD3, 1'b1, w);
        drain();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(2'd0, 4'(2 + i), 1'b1, 64'hD0 + 64'(i)));
        expect_flits("t4_flit");

        // 5: sequence wrap on source 3, parity bit
        do_reset();
        for (int k = 0; k < 17; k++) begin
            p = 64'h0123_4567_89AB_CDEF ^ 64'(k * 7);
            send(2'd3, p, 1'b1, w);
            exp_q.push_back(mk(2'd3, 4'(k), 1'b1, p));
        end
        drain();
        for (int i = 0; i < got.size(); i++) begin
`ifdef AIB_TX_ARB_PARITY_EN
            check("t5_even_parity", 72'(^got[i]), 72'(0));
`else
            check("t5_parity_zero", 72'(got[i][64]), 72'(0));
`endif
        end
        expect_flits("t5_flit");

        // 6: asynchronous reset while locked with one flit buffered
        tx_ready = 1'b0;
        send(2'd1, 64'hE1, 1'b0, w);
        check("t6_pre_valid", 72'(tx_valid), 72'(1));
        check("t6_pre_locked", 72'(locked), 72'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 72'(tx_valid), 72'(0));
        check("t6_async_locked", 72'(locked), 72'(0));
        check("t6_async_data", tx_data, 72'(0));
        check("t6_async_ready", 72'(src_ready), 72'(0));
        #1;
        rst = 1'b0;
        got.delete();
        tx_ready = 1'b1;
        send(2'd2, 64'hF2, 1'b1, w);
        drain();
        exp_q.push_back(mk(2'd2, 4'd0, 1'b1, 64'hF2));
        expect_flits("t6_flit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
